// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of serial_adder_ctrl; SUB exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_adder_ctrl_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             START;
  logic             READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_IN;
  logic [WIDTH-1:0] SUM;
  logic             C_OUT;
  logic             BUSY;
  logic             DONE;
`ifdef SERIAL_ADD_SUB_EN
  logic             SUB;
`endif

`ifdef SERIAL_ADD_SUB_EN
  modport master (output START, A, B, C_IN, SUB, input READY, SUM, C_OUT, BUSY, DONE);
  modport slave  (input START, A, B, C_IN, SUB, output READY, SUM, C_OUT, BUSY, DONE);
`else
  modport master (output START, A, B, C_IN, input READY, SUM, C_OUT, BUSY, DONE);
  modport slave  (input START, A, B, C_IN, output READY, SUM, C_OUT, BUSY, DONE);
`endif

endinterface

// File: rtl/Full_Adder.sv
// One-bit full-adder cell used as the serial datapath.
module Full_Adder (
  input  logic X,
  input  logic Y,
  input  logic C_I,
  output logic SUM,
  output logic C_O
);

  assign SUM = X ^ Y ^ C_I;
  assign C_O = (X & Y) | (C_I & (X ^ Y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced over WIDTH cycles.
// Optional subtract mode via SERIAL_ADD_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  serial_adder_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, sum_q;
  logic             carry, cout_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1; C_IN is ignored in that mode.
  assign b_load = bus.SUB ? ~bus.B : bus.B;
  assign c_load = bus.SUB | bus.C_IN;
`else
  assign b_load = bus.B;
  assign c_load = bus.C_IN;
`endif

  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  Full_Adder u_fa (
    .X   (a_sh[0]),
    .Y   (b_sh[0]),
    .C_I (carry),
    .SUM (fa_sum),
    .C_O (fa_co)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.READY = 1'b0;
    bus.BUSY  = 1'b0;
    bus.DONE  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.READY = 1'b1;
        if (bus.START) state_nxt = RUN;
      end
      RUN: begin
        bus.BUSY = 1'b1;
        if (last_bit) state_nxt = FIN;
      end
      FIN: begin
        bus.DONE  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            a_sh  <= bus.A;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {fa_sum, res[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          // Output copy is taken from the final shift so SUM is already valid while DONE is high.
          if (last_bit) begin
            sum_q  <= {fa_sum, res[WIDTH-1:1]};
            cout_q <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SUM   = sum_q;
  assign bus.C_OUT = cout_q;

  status_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
    $onehot({bus.READY, bus.BUSY, bus.DONE}));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); honours SERIAL_ADD_SUB_EN when defined.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    int unsigned ua, ub, tot;
    ua = a;
    ub = b;
    if (sub) begin
      tot = (ua - ub) % (1 << W);
      return {(ua >= ub) ? 1'b1 : 1'b0, tot[W-1:0]};
    end
    tot = ua + ub + cin;
    return tot[W:0];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One operation from an IDLE sample point; returns one cycle after DONE (back in IDLE).
  // poke>=0 fires a stray START with A=0x70 during that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input string tag, input int poke,
                        output logic [W-1:0] s, output logic co);
    int lat;
    bit ready_seen, sum_moved;
    logic [W-1:0] s0;
    lat = -1;
    ready_seen = 0;
    sum_moved = 0;
    check({tag, "_ready_pre"}, bus.READY, 1);
    bus.A = a;
    bus.B = b;
    bus.C_IN = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.SUB = sub;
`endif
    bus.START = 1'b1;
    s0 = bus.SUM;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (i == poke) begin
        bus.START = 1'b1;
        bus.A = 8'h70;
      end else begin
        bus.START = 1'b0;
      end
      step();
      if (bus.DONE) begin
        lat = i + 1;
        break;
      end
      if (bus.READY) ready_seen = 1;
      if (bus.SUM !== s0) sum_moved = 1;
    end
    bus.START = 1'b0;
    check({tag, "_done_latency"}, lat, W);
    check({tag, "_ready_low_run"}, {31'b0, ready_seen}, 0);
    check({tag, "_sum_stable_run"}, {31'b0, sum_moved}, 0);
    check({tag, "_ready_low_fin"}, bus.READY, 0);
    s = bus.SUM;
    co = bus.C_OUT;
    step();
    check({tag, "_done_pulse_end"}, bus.DONE, 0);
    check({tag, "_ready_back"}, bus.READY, 1);
    check({tag, "_sum_hold"}, bus.SUM, s);
  endtask

  initial begin
    vec_t tbl[$];
    logic [W-1:0] s, ra, rb;
    logic co, rc, rs;
    logic [W:0] ref_v;
    int done_cyc[$];
    int cyc, k;
    logic [W-1:0] b2b_a[3], b2b_b[3];

    tbl.push_back('{a: 8'h3C, b: 8'h5A, cin: 1'b0, sub: 1'b0, exp_sum: 8'h96, exp_cout: 1'b0});
    tbl.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1});
    tbl.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b1});
    tbl.push_back('{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, exp_sum: 8'h01, exp_cout: 1'b0});
    tbl.push_back('{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    tbl.push_back('{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b1, exp_sum: 8'hF0, exp_cout: 1'b0});
    tbl.push_back('{a: 8'h20, b: 8'h10, cin: 1'b0, sub: 1'b1, exp_sum: 8'h10, exp_cout: 1'b1});
    tbl.push_back('{a: 8'h55, b: 8'h55, cin: 1'b1, sub: 1'b1, exp_sum: 8'h00, exp_cout: 1'b1});
    bus.SUB = 1'b0;
`endif
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.C_IN = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ready", bus.READY, 1);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_sum", bus.SUM, 0);
    check("rst_cout", bus.C_OUT, 0);
    RST_N = 1'b1;
    step();

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, $sformatf("tbl%0d", i), -1, s, co);
      check($sformatf("tbl%0d_sum", i), s, tbl[i].exp_sum);
      check($sformatf("tbl%0d_cout", i), co, tbl[i].exp_cout);
    end

    // Stray START during RUN is ignored
    run_op(8'h01, 8'h02, 1'b0, 1'b0, "ign", 3, s, co);
    check("ign_sum", s, 8'h03);
    check("ign_cout", co, 0);
    step();
    check("ign_no_reaccept", bus.READY, 1);

    // Reset mid-RUN discards the partial result
    bus.A = 8'h3C;
    bus.B = 8'h5A;
    bus.C_IN = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_busy", bus.BUSY, 1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    check("mid_ready", bus.READY, 1);
    check("mid_busy_clr", bus.BUSY, 0);
    check("mid_done", bus.DONE, 0);
    check("mid_sum", bus.SUM, 0);
    check("mid_cout", bus.C_OUT, 0);
    step();
    check("mid_no_done", bus.DONE, 0);
    run_op(8'h05, 8'h06, 1'b0, 1'b0, "post", -1, s, co);
    check("post_sum", s, 8'h0B);
    check("post_cout", co, 0);

    // Back-to-back with START held high
    b2b_a = '{8'h11, 8'hF0, 8'h7F};
    b2b_b = '{8'h22, 8'h20, 8'h81};
    k = 0;
    cyc = 0;
    bus.C_IN = 1'b0;
    bus.A = b2b_a[0];
    bus.B = b2b_b[0];
    bus.START = 1'b1;
    while (k < 3 && cyc < 60) begin
      step();
      cyc++;
      if (bus.DONE) begin
        ref_v = model(b2b_a[k], b2b_b[k], 1'b0, 1'b0);
        check($sformatf("b2b%0d_sum", k), bus.SUM, ref_v[W-1:0]);
        check($sformatf("b2b%0d_cout", k), bus.C_OUT, ref_v[W]);
        done_cyc.push_back(cyc);
        k++;
        if (k < 3) begin
          bus.A = b2b_a[k];
          bus.B = b2b_b[k];
        end else begin
          bus.START = 1'b0;
        end
      end
    end
    bus.START = 1'b0;
    check("b2b_count", k, 3);
    for (int i = 1; i < done_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), done_cyc[i] - done_cyc[i-1], W + 2);
    step();
    step();

    // Randomized against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      ref_v = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, $sformatf("rnd%0d", i), -1, s, co);
      check($sformatf("rnd%0d_sum", i), s, ref_v[W-1:0]);
      check($sformatf("rnd%0d_cout", i), co, ref_v[W]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
